// File: rtl/proc_decode_stage.sv
// RV32I OP/OP-IMM decode stage feeding execute through a registered 2-entry skid buffer.
// Optional transfer counters are enabled with `define PROC_DECODE_STATS_EN.
package proc_pkg;
  typedef enum logic [1:0] {ARITH = 2'd0, LOGIC = 2'd1, SHIFT = 2'd2} alu_mux_sel_t;
  typedef enum logic {REG1_DATA = 1'b0, PC_ADDR = 1'b1} x_op1_mux_sel_t;
  typedef enum logic {REG2_DATA = 1'b0, IMM_SIGNED = 1'b1} x_op2_mux_sel_t;
  typedef enum logic {REG_WRITE = 1'b0, MEM_READ = 1'b1} w_mux_sel_t;
endpackage

module proc_decode_stage
  import proc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output alu_mux_sel_t         out_alu_sel,
  output x_op1_mux_sel_t       out_op1_sel,
  output x_op2_mux_sel_t       out_op2_sel,
  output w_mux_sel_t           out_w_sel,
  output logic [3:0]           out_alu_fn,
  output logic [RF_AW-1:0]     out_rs1,
  output logic [RF_AW-1:0]     out_rs2,
  output logic [RF_AW-1:0]     out_rd,
  output logic [XLEN-1:0]      out_imm,
  output logic                 out_we,
`ifdef PROC_DECODE_STATS_EN
  output logic [31:0]          stat_decoded,
  output logic [31:0]          stat_illegal,
`endif
  output logic                 out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    alu_mux_sel_t         alu_sel;
    x_op1_mux_sel_t       op1_sel;
    x_op2_mux_sel_t       op2_sel;
    w_mux_sel_t           w_sel;
    logic [3:0]           alu_fn;
    logic [RF_AW-1:0]     rs1;
    logic [RF_AW-1:0]     rs2;
    logic [RF_AW-1:0]     rd;
    logic [XLEN-1:0]      imm;
    logic                 we;
    logic                 illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  bundle_t      dec_d, m_q, s_q;
  state_t       st_q;
  logic         in_ready_q, out_valid_q;
  logic         in_xfer, out_xfer, legal;
  alu_mux_sel_t alu_raw;

  wire [6:0] opc = in_instr[6:0];
  wire [2:0] f3  = in_instr[14:12];
  wire [6:0] f7  = in_instr[31:25];

  always_comb begin
    unique case (f3)
      3'b001, 3'b101:         alu_raw = SHIFT;
      3'b100, 3'b110, 3'b111: alu_raw = LOGIC;
      default:                alu_raw = ARITH;
    endcase
  end

  // Illegal words still carry their raw fields; only we/alu_sel/illegal are overridden.
  always_comb begin
    dec_d         = '0;
    dec_d.op1_sel = REG1_DATA;
    dec_d.op2_sel = REG2_DATA;
    dec_d.w_sel   = REG_WRITE;
    dec_d.alu_fn  = {in_instr[30], f3};
    dec_d.rs1     = in_instr[19:15];
    dec_d.rs2     = in_instr[24:20];
    dec_d.rd      = in_instr[11:7];
    dec_d.imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    legal         = 1'b0;
    case (opc)
      OPC_OP: legal = (f7 == 7'b0000000) ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      OPC_OP_IMM: begin
        dec_d.op2_sel = IMM_SIGNED;
        dec_d.alu_fn  = {(f3 == 3'b101) & in_instr[30], f3};
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec_d.illegal = !legal;
    dec_d.we      = legal && (in_instr[11:7] != 5'd0);
    dec_d.alu_sel = legal ? alu_raw : ARITH;
  end

  assign in_xfer  = in_valid & in_ready_q & ~flush;
  assign out_xfer = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      st_q        <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (st_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            m_q         <= dec_d;
            st_q        <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (out_xfer && in_xfer) begin
            m_q <= dec_d;
          end else if (out_xfer) begin
            st_q        <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (in_xfer) begin
            // M stalled this cycle: park the newcomer in S and close the input.
            s_q        <= dec_d;
            st_q       <= TWO;
            in_ready_q <= 1'b0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            m_q        <= s_q;
            st_q       <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          st_q        <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_alu_sel = m_q.alu_sel;
  assign out_op1_sel = m_q.op1_sel;
  assign out_op2_sel = m_q.op2_sel;
  assign out_w_sel   = m_q.w_sel;
  assign out_alu_fn  = m_q.alu_fn;
  assign out_rs1     = m_q.rs1;
  assign out_rs2     = m_q.rs2;
  assign out_rd      = m_q.rd;
  assign out_imm     = m_q.imm;
  assign out_we      = m_q.we;
  assign out_illegal = m_q.illegal;

`ifdef PROC_DECODE_STATS_EN
  logic [31:0] stat_decoded_q, stat_illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_decoded_q <= '0;
      stat_illegal_q <= '0;
    end else if (out_xfer) begin
      stat_decoded_q <= stat_decoded_q + 32'd1;
      if (m_q.illegal) stat_illegal_q <= stat_illegal_q + 32'd1;
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_proc_decode_stage.sv
// Directed-vector bench for proc_decode_stage: decode fields, skid-buffer flow, flush and reset.
module tb_proc_decode_stage;
  import proc_pkg::*;

  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  alu_mux_sel_t   out_alu_sel;
  x_op1_mux_sel_t out_op1_sel;
  x_op2_mux_sel_t out_op2_sel;
  w_mux_sel_t     out_w_sel;
  logic [3:0]  out_alu_fn;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_we, out_illegal;
`ifdef PROC_DECODE_STATS_EN
  logic [31:0] stat_decoded, stat_illegal;
`endif

  int n_chk = 0, n_bad = 0;

  always #5 clk = ~clk;

  proc_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_sel(out_alu_sel), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_w_sel(out_w_sel), .out_alu_fn(out_alu_fn),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_we(out_we),
`ifdef PROC_DECODE_STATS_EN
    .stat_decoded(stat_decoded), .stat_illegal(stat_illegal),
`endif
    .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1'b1; in_instr = ins;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    #3;
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_iready", 32'(in_ready), 0);
    chk("rst_imm",    out_imm, 0);
    chk("rst_alusel", 32'(out_alu_sel), 0);
    chk("rst_op2",    32'(out_op2_sel), 0);
    chk("rst_rd",     32'(out_rd), 0);
    step(); rst = 1'b0;
    chk("rel_iready0", 32'(in_ready), 0);
    step();
    chk("rel_iready1", 32'(in_ready), 1);

    // ADDI x5,x1,-3
    out_ready = 1'b1;
    issue(32'hFFD08293);
    chk("addi_vld",  32'(out_valid), 1);
    chk("addi_alu",  32'(out_alu_sel), 32'(ARITH));
    chk("addi_op1",  32'(out_op1_sel), 32'(REG1_DATA));
    chk("addi_op2",  32'(out_op2_sel), 32'(IMM_SIGNED));
    chk("addi_wsel", 32'(out_w_sel), 32'(REG_WRITE));
    chk("addi_imm",  out_imm, 32'hFFFFFFFD);
    chk("addi_rd",   32'(out_rd), 5);
    chk("addi_rs1",  32'(out_rs1), 1);
    chk("addi_we",   32'(out_we), 1);
    chk("addi_fn",   32'(out_alu_fn), 0);
    chk("addi_ill",  32'(out_illegal), 0);

    // SRA x3,x4,x6
    issue(32'h406251B3);
    chk("sra_alu", 32'(out_alu_sel), 32'(SHIFT));
    chk("sra_op2", 32'(out_op2_sel), 32'(REG2_DATA));
    chk("sra_fn",  32'(out_alu_fn), 32'hD);
    chk("sra_rs2", 32'(out_rs2), 6);
    chk("sra_we",  32'(out_we), 1);
    chk("sra_ill", 32'(out_illegal), 0);

    // SUB with funct7=0100001 is not a legal encoding
    issue(32'h426201B3);
    chk("badsub_ill", 32'(out_illegal), 1);
    chk("badsub_we",  32'(out_we), 0);
    chk("badsub_alu", 32'(out_alu_sel), 32'(ARITH));
    chk("badsub_rd",  32'(out_rd), 3);

    // SRAI x1,x1,3: instr[30] reaches alu_fn[3]
    issue(32'h4030D093);
    chk("srai_fn",  32'(out_alu_fn), 32'hD);
    chk("srai_alu", 32'(out_alu_sel), 32'(SHIFT));
    chk("srai_imm", out_imm, 32'h00000403);
    chk("srai_ill", 32'(out_illegal), 0);

    // ANDI x2,x2,-1: instr[30]=1 must not leak into alu_fn
    issue(32'hFFF17113);
    chk("andi_fn",  32'(out_alu_fn), 32'h7);
    chk("andi_alu", 32'(out_alu_sel), 32'(LOGIC));
    chk("andi_imm", out_imm, 32'hFFFFFFFF);

    // SLLI x1,x1,1 with imm[11:5]=0100000 is illegal
    issue(32'h40109093);
    chk("badslli_ill", 32'(out_illegal), 1);

    issue(32'h0000006F);
    chk("jal_ill", 32'(out_illegal), 1);
    chk("jal_we",  32'(out_we), 0);
    chk("jal_alu", 32'(out_alu_sel), 32'(ARITH));

    issue(32'h00000013);
    chk("nop_we",  32'(out_we), 0);
    chk("nop_ill", 32'(out_illegal), 0);
    step();
    chk("drain_vld", 32'(out_valid), 0);

    // Stall: ADD x1, AND x4, SLLI x7 with out_ready low for 2 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h003100B3;
    step();
    chk("st1_vld", 32'(out_valid), 1);
    chk("st1_rd",  32'(out_rd), 1);
    in_instr = 32'h0062F233;
    step();
    chk("st2_irdy", 32'(in_ready), 0);
    chk("st2_rd",   32'(out_rd), 1);
    in_instr = 32'h00241393;
    step();
    chk("st3_irdy", 32'(in_ready), 0);
    chk("st3_rd",   32'(out_rd), 1);
    chk("st3_fn",   32'(out_alu_fn), 0);
    out_ready = 1'b1;
    step();
    chk("st4_rd",   32'(out_rd), 4);
    chk("st4_alu",  32'(out_alu_sel), 32'(LOGIC));
    chk("st4_irdy", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("st5_rd",  32'(out_rd), 7);
    chk("st5_alu", 32'(out_alu_sel), 32'(SHIFT));
    chk("st5_imm", out_imm, 32'h2);
    step();
    chk("st6_vld", 32'(out_valid), 0);

    // Flush from TWO with input offered
    out_ready = 1'b0;
    issue(32'h003100B3);
    issue(32'h0062F233);
    chk("fl_two_irdy", 32'(in_ready), 0);
    in_valid = 1'b1; in_instr = 32'h00241393; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld",  32'(out_valid), 0);
    chk("fl_irdy", 32'(in_ready), 1);
    out_ready = 1'b1;
    step();
    chk("fl_gone", 32'(out_valid), 0);

    // Flush from ONE while in_ready=1: offered word is dropped
    out_ready = 1'b0;
    issue(32'h003100B3);
    in_valid = 1'b1; in_instr = 32'h00241393; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_vld", 32'(out_valid), 0);
    out_ready = 1'b1;
    step();
    chk("fl1_gone", 32'(out_valid), 0);

    // Async reset mid-stall
    out_ready = 1'b0;
    issue(32'hFFD08293);
    chk("ar_pre_vld", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("ar_vld",  32'(out_valid), 0);
    chk("ar_irdy", 32'(in_ready), 0);
    chk("ar_imm",  out_imm, 0);
    step(); rst = 1'b0;
    step();
    chk("ar_irdy1", 32'(in_ready), 1);

`ifdef PROC_DECODE_STATS_EN
    chk("st_rst_dec", stat_decoded, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) issue(32'h0000006F);
      else issue(32'h003100B3);
    end
    step();
    chk("st_dec", stat_decoded, 10);
    chk("st_ill", stat_illegal, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_fl_dec", stat_decoded, 10);
    chk("st_fl_ill", stat_illegal, 3);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
